// File: rtl/uart_tx_engine.sv
// ---------------------------------------------------------------------------
// uart_tx_engine
//
// UART transmit engine: accepts one parallel word over a valid/ready
// handshake and serialises it as start bit, data bits LSB-first, an optional
// parity bit and one or two stop bits. Bit timing is taken from an external
// one-clock-wide baud tick; one tick marks the boundary of one bit period.
//
// Build option:
//   UART_TX_PARITY_EN - when defined, one parity bit (even, or odd when
//                       PARITY_ODD != 0) is sent after the data bits. When
//                       undefined the parity state and logic are absent and
//                       PARITY_ODD has no effect.
//
// Parameters:
//   DATA_BITS  - data bits per frame (5..9)
//   STOP_BITS  - stop bits per frame (1 or 2)
//   PARITY_ODD - 0 = even parity, 1 = odd parity
//
// Ports:
//   clock    in   system clock, rising edge
//   reset    in   synchronous, active-low reset
//   baud     in   one-clock baud tick
//   tx_valid in   host offers tx_data
//   tx_data  in   word to send
//   tx_ready out  engine can accept a word (registered)
//   tx       out  serial line, idle high (registered)
//   busy     out  high from acceptance until frame end (registered)
//   done     out  one-clock pulse in the cycle whose edge ends the last
//                 stop bit; tx_ready is high on the following cycle
// ---------------------------------------------------------------------------
module uart_tx_engine #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 baud,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int BCW = $clog2(DATA_BITS);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] BIT_ONE   = BCW'(1);
  localparam logic           STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic                   tx_q, tx_d;
  logic                   tx_ready_q, tx_ready_d;
  logic                   busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;

  // Parity of the word as captured at transfer; odd parity inverts the XOR.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] word);
    calc_parity = (^word) ^ (PARITY_ODD != 0);
  endfunction
`endif

  assign tx       = tx_q;
  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      shreg_q    <= {DATA_BITS{1'b0}};
      bit_cnt_q  <= {BCW{1'b0}};
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  // Next-state logic: every move except IDLE->WAIT waits for a baud tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (tx_valid && tx_ready_q) state_d = S_WAIT;
        else                        state_d = S_IDLE;
      end
      // A tick on the transfer edge is seen here only from the next cycle,
      // so the start bit always spans a full baud period.
      S_WAIT: begin
        if (baud) state_d = S_START;
        else      state_d = S_WAIT;
      end
      S_START: begin
        if (baud) state_d = S_DATA;
        else      state_d = S_START;
      end
      S_DATA: begin
        if (baud && (bit_cnt_q >= BIT_LAST)) begin
`ifdef UART_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud) state_d = S_STOP;
        else      state_d = S_PARITY;
      end
`endif
      S_STOP: begin
        if (baud && (stop_cnt_q == STOP_LAST)) state_d = S_IDLE;
        else                                   state_d = S_STOP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath logic: line value, shifter, counters, handshake.
  always_comb begin
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    tx_ready_d = tx_ready_q;
    busy_d     = busy_q;
    done       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (tx_valid && tx_ready_q) begin
          shreg_d    = tx_data;
          tx_ready_d = 1'b0;
          busy_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d   = calc_parity(tx_data);
`endif
        end else begin
          tx_ready_d = 1'b1;
          busy_d     = 1'b0;
        end
      end
      S_WAIT: begin
        if (baud) tx_d = 1'b0;
        else      tx_d = tx_q;
      end
      S_START: begin
        if (baud) begin
          tx_d      = shreg_q[0];
          shreg_d   = {1'b0, shreg_q[DATA_BITS-1:1]};
          bit_cnt_d = {BCW{1'b0}};
        end else begin
          tx_d = tx_q;
        end
      end
      S_DATA: begin
        if (baud && (bit_cnt_q < BIT_LAST)) begin
          tx_d      = shreg_q[0];
          shreg_d   = {1'b0, shreg_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_ONE;
        end else if (baud) begin
`ifdef UART_TX_PARITY_EN
          tx_d       = parity_q;
`else
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
`endif
        end else begin
          tx_d = tx_q;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end else begin
          tx_d = tx_q;
        end
      end
`endif
      S_STOP: begin
        if (baud && (stop_cnt_q == STOP_LAST)) begin
          tx_ready_d = 1'b1;
          busy_d     = 1'b0;
          // An abandoned frame (reset this edge) never reports completion.
          done       = reset;
        end else if (baud) begin
          stop_cnt_d = 1'b1;
        end else begin
          stop_cnt_d = stop_cnt_q;
        end
      end
      default: begin
        tx_d       = 1'b1;
        tx_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end

endmodule
